alu_issue_stage: RTL and testbench

Decode-and-issue pipeline that drives the combinational ALU and collects its result. It accepts RV32I OP/OP-IMM instruction words with register operands over a valid/ready handshake. Each instruction is decoded into a `t_aluop`, `op_a` and `op_b`, which are held in a decode register that drives the ALU. The ALU result is captured in a writeback register and presented downstream with its destination register over a second valid/ready handshake.

---
 rtl/alu_issue_stage.sv | 199 +++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Decode-and-issue stage for RV32I OP / OP-IMM instructions. An accepted
//   instruction is decoded into an ALU function and two operands held in the
//   decode register (D), which drives an external combinational ALU. The ALU
//   result is captured in the writeback register (W) together with rd and an
//   illegal flag, and offered downstream.
//
// Ports
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_valid / o_ready               upstream instruction handshake
//   i_instr, i_rs1_data, i_rs2_data instruction word and register operands
//   o_alu_funct/op_a/op_b           registered ALU controls (from D)
//   i_alu_result                    combinational ALU result for o_alu_*
//   o_wb_valid / i_wb_ready         downstream writeback handshake
//   o_wb_rd, o_wb_data, o_wb_illegal writeback entry (from W)

package multicore_pkg;
    localparam int DATA_SIZE = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } t_aluop;
endpackage

module alu_issue_stage
    import multicore_pkg::*;
#(
    parameter int DATA_SIZE = multicore_pkg::DATA_SIZE
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [31:0]          i_instr,
    input  logic [DATA_SIZE-1:0] i_rs1_data,
    input  logic [DATA_SIZE-1:0] i_rs2_data,
    output t_aluop               o_alu_funct,
    output logic [DATA_SIZE-1:0] o_alu_op_a,
    output logic [DATA_SIZE-1:0] o_alu_op_b,
    input  logic [DATA_SIZE-1:0] i_alu_result,
    output logic                 o_wb_valid,
    input  logic                 i_wb_ready,
    output logic [4:0]           o_wb_rd,
    output logic [DATA_SIZE-1:0] o_wb_data,
    output logic                 o_wb_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];
    assign funct7 = i_instr[31:25];

    // rs1 index field is not needed: operand values arrive pre-read.
    logic unused_rs1_idx;
    assign unused_rs1_idx = ^i_instr[19:15];

    logic [DATA_SIZE-1:0] imm_sext, shamt_imm, shamt_rs2;
    assign imm_sext  = {{(DATA_SIZE-12){i_instr[31]}}, i_instr[31:20]};
    assign shamt_imm = {{(DATA_SIZE-5){1'b0}}, i_instr[24:20]};
    assign shamt_rs2 = {{(DATA_SIZE-5){1'b0}}, i_rs2_data[4:0]};

    // Decode
    t_aluop               dec_funct;
    logic [DATA_SIZE-1:0] dec_op_a, dec_op_b;
    logic                 dec_illegal;
    logic [4:0]           dec_rd;

    always_comb begin
        dec_funct   = ALU_ADD;
        dec_op_a    = i_rs1_data;
        dec_op_b    = i_rs2_data;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000: dec_funct = ALU_ADD;
                        3'b001: dec_funct = ALU_SLL;
                        3'b010: dec_funct = ALU_SLT;
                        3'b011: dec_funct = ALU_SLTU;
                        3'b100: dec_funct = ALU_XOR;
                        3'b101: dec_funct = ALU_SRL;
                        3'b110: dec_funct = ALU_OR;
                        3'b111: dec_funct = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_funct = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_funct = ALU_SRA;
                end else begin
                    dec_illegal = 1'b1;
                end
                // Register shifts only use the low 5 bits of rs2.
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    dec_op_b = shamt_rs2;
            end
            OPC_OP_IMM: begin
                dec_op_b = imm_sext;
                case (funct3)
                    3'b000: dec_funct = ALU_ADD;
                    3'b010: dec_funct = ALU_SLT;
                    3'b011: dec_funct = ALU_SLTU;
                    3'b100: dec_funct = ALU_XOR;
                    3'b110: dec_funct = ALU_OR;
                    3'b111: dec_funct = ALU_AND;
                    3'b001: begin
                        dec_funct = ALU_SLL;
                        dec_op_b  = shamt_imm;
                        if (funct7 != F7_BASE) dec_illegal = 1'b1;
                    end
                    3'b101: begin
                        dec_op_b = shamt_imm;
                        if (funct7 == F7_BASE)     dec_funct = ALU_SRL;
                        else if (funct7 == F7_ALT) dec_funct = ALU_SRA;
                        else                       dec_illegal = 1'b1;
                    end
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
        // Illegal entries become a harmless ADD 0,0 so the ALU output is benign.
        if (dec_illegal) begin
            dec_funct = ALU_ADD;
            dec_op_a  = '0;
            dec_op_b  = '0;
        end
    end

    assign dec_rd = dec_illegal ? 5'd0 : i_instr[11:7];

    // Pipeline control
    logic       d_valid;
    logic [4:0] d_rd;
    logic       d_illegal;
    logic       w_adv, d_adv, accept;

    assign w_adv   = !o_wb_valid || i_wb_ready;
    assign d_adv   = d_valid && w_adv;
    assign o_ready = !d_valid || w_adv;
    assign accept  = i_valid && o_ready;

    // D stage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            d_valid     <= 1'b0;
            d_rd        <= 5'd0;
            d_illegal   <= 1'b0;
            o_alu_funct <= ALU_ADD;
            o_alu_op_a  <= '0;
            o_alu_op_b  <= '0;
        end else begin
            if (accept) begin
                d_valid     <= 1'b1;
                d_rd        <= dec_rd;
                d_illegal   <= dec_illegal;
                o_alu_funct <= dec_funct;
                o_alu_op_a  <= dec_op_a;
                o_alu_op_b  <= dec_op_b;
            end else if (d_adv) begin
                d_valid <= 1'b0;
            end
        end
    end

    // W stage: x0 writes always carry zero data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wb_valid   <= 1'b0;
            o_wb_rd      <= 5'd0;
            o_wb_data    <= '0;
            o_wb_illegal <= 1'b0;
        end else if (w_adv) begin
            o_wb_valid <= d_valid;
            if (d_valid) begin
                o_wb_rd      <= d_rd;
                o_wb_data    <= (d_rd == 5'd0) ? '0 : i_alu_result;
                o_wb_illegal <= d_illegal;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
    import multicore_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr, i_rs1_data, i_rs2_data;
    t_aluop      o_alu_funct;
    logic [31:0] o_alu_op_a, o_alu_op_b, i_alu_result;
    logic        o_wb_valid, i_wb_ready;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_wb_illegal;

    alu_issue_stage dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_instr(i_instr), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
        .o_alu_funct(o_alu_funct), .o_alu_op_a(o_alu_op_a), .o_alu_op_b(o_alu_op_b),
        .i_alu_result(i_alu_result),
        .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready),
        .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data), .o_wb_illegal(o_wb_illegal)
    );

    always #5 i_clk = ~i_clk;

    // Reference combinational ALU driven by the DUT's issue outputs.
    always_comb begin
        case (o_alu_funct)
            ALU_ADD:  i_alu_result = o_alu_op_a + o_alu_op_b;
            ALU_SUB:  i_alu_result = o_alu_op_a - o_alu_op_b;
            ALU_SLL:  i_alu_result = o_alu_op_a << o_alu_op_b[4:0];
            ALU_SLT:  i_alu_result = {31'b0, $signed(o_alu_op_a) < $signed(o_alu_op_b)};
            ALU_SLTU: i_alu_result = {31'b0, o_alu_op_a < o_alu_op_b};
            ALU_XOR:  i_alu_result = o_alu_op_a ^ o_alu_op_b;
            ALU_SRL:  i_alu_result = o_alu_op_a >> o_alu_op_b[4:0];
            ALU_SRA:  i_alu_result = $signed(o_alu_op_a) >>> o_alu_op_b[4:0];
            ALU_OR:   i_alu_result = o_alu_op_a | o_alu_op_b;
            ALU_AND:  i_alu_result = o_alu_op_a & o_alu_op_b;
            default:  i_alu_result = 32'h0;
        endcase
    end

    int errs = 0;
    int nchk = 0;
    int wb_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic        ill;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Scoreboard: every completed writeback must match the next expected entry.
    always @(negedge i_clk) begin
        if (i_rst_n && o_wb_valid && i_wb_ready) begin
            wb_cnt++;
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_rd", 32'(o_wb_rd), 32'(e.rd));
                chk("wb_data", o_wb_data, e.data);
                chk("wb_illegal", 32'(o_wb_illegal), 32'(e.ill));
            end
        end
    end

    // Stall stability: W contents must not move while held off.
    logic        stall_q = 1'b0;
    logic [4:0]  hold_rd;
    logic [31:0] hold_data;
    logic        hold_ill;
    always @(negedge i_clk) begin
        if (i_rst_n && o_wb_valid && stall_q) begin
            chk("stall_rd", 32'(o_wb_rd), 32'(hold_rd));
            chk("stall_data", o_wb_data, hold_data);
            chk("stall_ill", 32'(o_wb_illegal), 32'(hold_ill));
        end
        stall_q   = i_rst_n && o_wb_valid && !i_wb_ready;
        hold_rd   = o_wb_rd;
        hold_data = o_wb_data;
        hold_ill  = o_wb_illegal;
    end

    function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_op(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
        return {imm, 5'd1, f3, rd, 7'b0010011};
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Present one instruction, return 1 time unit after the edge that took it.
    task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] data, input logic ill);
        int n;
        exp_t e;
        e.ill = ill; e.rd = rd; e.data = data;
        exp_q.push_back(e);
        i_valid = 1'b1; i_instr = ins; i_rs1_data = a; i_rs2_data = b;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_ready && n < 100);
        if (n >= 100) chk("accept_timeout", 32'(n), 32'd0);
        step();
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge i_clk);
            #1;
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        step();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, 32'(o_ready), 32'd1);
        chk({tag, "_wbv"}, 32'(o_wb_valid), 32'd0);
        chk({tag, "_funct"}, 32'(o_alu_funct), 32'(ALU_ADD));
        chk({tag, "_opa"}, o_alu_op_a, 32'h0);
        chk({tag, "_opb"}, o_alu_op_b, 32'h0);
        chk({tag, "_rd"}, 32'(o_wb_rd), 32'd0);
        chk({tag, "_data"}, o_wb_data, 32'h0);
        chk({tag, "_ill"}, 32'(o_wb_illegal), 32'd0);
    endtask

    int cnt0;

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_wb_ready = 1'b1;
        i_instr = 32'h0; i_rs1_data = 32'h0; i_rs2_data = 32'h0;
        repeat (2) @(negedge i_clk);
        chk_reset_state("rst");
        step();
        i_rst_n = 1'b1;
        step();

        // Latency: add x3 = 5 + 7
        send(r_op(7'h00, 3'b000, 5'd3), 32'd5, 32'd7, 5'd3, 32'd12, 1'b0);
        @(negedge i_clk);
        chk("lat_funct", 32'(o_alu_funct), 32'(ALU_ADD));
        chk("lat_opa", o_alu_op_a, 32'd5);
        chk("lat_opb", o_alu_op_b, 32'd7);
        chk("lat_wbv0", 32'(o_wb_valid), 32'd0);
        @(negedge i_clk);
        chk("lat_wbv1", 32'(o_wb_valid), 32'd1);
        step();

        // Back-to-back OP mix, one result per cycle
        cnt0 = wb_cnt;
        send(r_op(7'h20, 3'b000, 5'd4), 32'd5, 32'd7, 5'd4, 32'hFFFF_FFFE, 1'b0);
        send(r_op(7'h00, 3'b011, 5'd5), 32'hFFFF_FFFF, 32'd1, 5'd5, 32'd0, 1'b0);
        send(r_op(7'h00, 3'b010, 5'd6), 32'hFFFF_FFFF, 32'd1, 5'd6, 32'd1, 1'b0);
        send(r_op(7'h00, 3'b001, 5'd7), 32'd3, 32'h0000_0021, 5'd7, 32'd6, 1'b0);
        @(negedge i_clk); #1;
        chk("tput_3", 32'(wb_cnt - cnt0), 32'd3);
        @(negedge i_clk); #1;
        chk("tput_4", 32'(wb_cnt - cnt0), 32'd4);
        step();

        // OP-IMM
        send(i_op(12'hFFF, 3'b000, 5'd1), 32'd1, 32'h0, 5'd1, 32'd0, 1'b0);
        send(i_op({7'b0100000, 5'd4}, 3'b101, 5'd2), 32'h8000_0000, 32'h0, 5'd2, 32'hF800_0000, 1'b0);
        drain();

        // Illegal entries flow in order; a following legal op is unaffected
        send({12'h004, 5'd1, 3'b010, 5'd6, 7'b0000011}, 32'h1234, 32'h5678, 5'd0, 32'd0, 1'b1);
        @(negedge i_clk);
        chk("ill_opa", o_alu_op_a, 32'h0);
        chk("ill_opb", o_alu_op_b, 32'h0);
        step();
        send(i_op({7'b0000001, 5'd3}, 3'b001, 5'd5), 32'h1234, 32'h0, 5'd0, 32'd0, 1'b1);
        send(i_op(12'd5, 3'b000, 5'd12), 32'd10, 32'h0, 5'd12, 32'd15, 1'b0);
        drain();

        // x0 destination
        send(r_op(7'h00, 3'b000, 5'd0), 32'd3, 32'd4, 5'd0, 32'd0, 1'b0);
        drain();

        // Backpressure: fill W and D, then hold the third instruction
        i_wb_ready = 1'b0;
        cnt0 = wb_cnt;
        send(r_op(7'h00, 3'b110, 5'd8), 32'h0000_F0F0, 32'h0000_0F00, 5'd8, 32'h0000_FFF0, 1'b0);
        send(r_op(7'h00, 3'b100, 5'd9), 32'h0000_00FF, 32'h0000_000F, 5'd9, 32'h0000_00F0, 1'b0);
        i_valid = 1'b1; i_instr = r_op(7'h00, 3'b111, 5'd10);
        i_rs1_data = 32'h3C; i_rs2_data = 32'h0F;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            chk("bp_ready", 32'(o_ready), 32'd0);
            chk("bp_hold_opa", o_alu_op_a, 32'h0000_00FF);
            chk("bp_wb_rd", 32'(o_wb_rd), 32'd8);
        end
        chk("bp_no_wb", 32'(wb_cnt - cnt0), 32'd0);
        step();
        // Release: drain W, move D, accept new instruction on the same edge
        i_wb_ready = 1'b1;
        send(r_op(7'h00, 3'b111, 5'd10), 32'h3C, 32'h0F, 5'd10, 32'h0000_000C, 1'b0);
        @(negedge i_clk);
        chk("nobub_wbv", 32'(o_wb_valid), 32'd1);
        chk("nobub_wbrd", 32'(o_wb_rd), 32'd9);
        chk("nobub_opa", o_alu_op_a, 32'h3C);
        step();
        send(r_op(7'h00, 3'b101, 5'd11), 32'h8000_0000, 32'd4, 5'd11, 32'h0800_0000, 1'b0);
        drain();
        chk("bp_total", 32'(wb_cnt - cnt0), 32'd4);

        // Reset with both stages occupied: entries are dropped
        i_wb_ready = 1'b0;
        send(r_op(7'h00, 3'b000, 5'd13), 32'd1, 32'd1, 5'd13, 32'd2, 1'b0);
        send(r_op(7'h00, 3'b000, 5'd14), 32'd2, 32'd2, 5'd14, 32'd4, 1'b0);
        i_rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk_reset_state("midrst");
        step();
        i_rst_n = 1'b1;
        i_wb_ready = 1'b1;
        cnt0 = wb_cnt;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            chk("postrst_wbv", 32'(o_wb_valid), 32'd0);
        end
        step();
        send(r_op(7'h00, 3'b000, 5'd15), 32'd6, 32'd7, 5'd15, 32'd13, 1'b0);
        drain();
        chk("postrst_cnt", 32'(wb_cnt - cnt0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
